// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution unit: op codes,
// ARM condition codes and the sequential PC increment.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE  = 3'd0,
        BR_B     = 3'd1,
        BR_CBZ   = 3'd2,
        BR_CBNZ  = 3'd3,
        BR_BCOND = 3'd4
    } br_op_t;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator against an {N,Z,C,V} flag set.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = i_nzcv;

    always_comb begin
        o_pass = 1'b1;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            default: o_pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage with a single result register and NZCV flag register.
// Define BRANCH_FLAG_FWD_EN to let a BCOND see flags written in the same cycle.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  br_op_t          in_op,
    input  logic [3:0]      in_cond,
    input  logic [PC_W-1:0] in_pc,
    input  logic [PC_W-1:0] in_target,
    input  logic            in_zero,
    input  logic            set_flags,
    input  logic [3:0]      alu_nzcv,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [PC_W-1:0] out_next_pc,
    output logic [3:0]      flags_q
);

    logic            r_valid;
    logic            r_taken;
    logic [PC_W-1:0] r_next_pc;
    logic [3:0]      r_flags;

    logic [3:0]      w_eval_flags;
    logic            w_cond_pass;
    logic            w_taken;
    logic            w_accept;
    logic [PC_W-1:0] w_next_pc;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

`ifdef BRANCH_FLAG_FWD_EN
    assign w_eval_flags = set_flags ? alu_nzcv : r_flags;
`else
    assign w_eval_flags = r_flags;
`endif

    cond_eval u_cond_eval (
        .i_cond (in_cond),
        .i_nzcv (w_eval_flags),
        .o_pass (w_cond_pass)
    );

    always_comb begin
        w_taken = 1'b0;
        case (in_op)
            BR_B:     w_taken = 1'b1;
            BR_CBZ:   w_taken = in_zero;
            BR_CBNZ:  w_taken = !in_zero;
            BR_BCOND: w_taken = w_cond_pass;
            default:  w_taken = 1'b0;
        endcase
    end

    assign w_next_pc = w_taken ? in_target : (in_pc + PC_W'(PC_INC));

    // Flush outranks both drain and accept; taken/next_pc simply hold when not loaded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_taken   <= 1'b0;
            r_next_pc <= '0;
            r_flags   <= 4'b0000;
        end else begin
            if (set_flags) begin
                r_flags <= alu_nzcv;
            end
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid   <= 1'b1;
                r_taken   <= w_taken;
                r_next_pc <= w_next_pc;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_taken   = r_taken;
    assign out_next_pc = r_next_pc;
    assign flags_q     = r_flags;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_branch_resolve;
    import branch_pkg::*;

    localparam int PC_W = 64;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    br_op_t          in_op;
    logic [3:0]      in_cond;
    logic [PC_W-1:0] in_pc;
    logic [PC_W-1:0] in_target;
    logic            in_zero;
    logic            set_flags;
    logic [3:0]      alu_nzcv;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [PC_W-1:0] out_next_pc;
    logic [3:0]      flags_q;

    int checks = 0;
    int errors = 0;

    logic            mValid;
    logic            mTaken;
    logic [PC_W-1:0] mNextPc;
    logic [3:0]      mFlags;

    branch_resolve #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_cond     (in_cond),
        .in_pc       (in_pc),
        .in_target   (in_target),
        .in_zero     (in_zero),
        .set_flags   (set_flags),
        .alu_nzcv    (alu_nzcv),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_taken   (out_taken),
        .out_next_pc (out_next_pc),
        .flags_q     (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARM-style decode: cond[3:1] picks a base test, cond[0] inverts it, 111x is always.
    function automatic bit condPass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, b;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cf;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cf && !z;
            3'd5:    b = (n == v);
            3'd6:    b = !z && (n == v);
            default: b = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return 1'b1;
        return b ^ c[0];
    endfunction

    function automatic bit modelTaken(input int op, input bit zero, input logic [3:0] c,
                                      input logic [3:0] f);
        case (op)
            1:       return 1'b1;
            2:       return zero;
            3:       return !zero;
            4:       return condPass(c, f);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] modelEvalFlags(input bit sf, input logic [3:0] nz,
                                                  input logic [3:0] cur);
`ifdef BRANCH_FLAG_FWD_EN
        return sf ? nz : cur;
`else
        return (sf && 1'b0) ? nz : cur;
`endif
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mValid  <= 1'b0;
            mTaken  <= 1'b0;
            mNextPc <= '0;
            mFlags  <= 4'b0000;
        end else begin
            if (set_flags) mFlags <= alu_nzcv;
            if (flush) begin
                mValid <= 1'b0;
            end else if (in_valid && (!mValid || out_ready)) begin
                mValid <= 1'b1;
                mTaken <= modelTaken(int'(in_op), in_zero, in_cond,
                                     modelEvalFlags(set_flags, alu_nzcv, mFlags));
                mNextPc <= modelTaken(int'(in_op), in_zero, in_cond,
                                      modelEvalFlags(set_flags, alu_nzcv, mFlags))
                           ? in_target : in_pc + 64'd4;
            end else if (out_ready) begin
                mValid <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            checkOutput("model.out_valid", 64'(out_valid), 64'(mValid));
            checkOutput("model.in_ready", 64'(in_ready), 64'(!mValid || out_ready));
            checkOutput("model.flags_q", 64'(flags_q), 64'(mFlags));
            if (mValid) begin
                checkOutput("model.out_taken", 64'(out_taken), 64'(mTaken));
                checkOutput("model.out_next_pc", out_next_pc, mNextPc);
            end
        end
    end

    task automatic applyStimulus(input bit v, input int op, input logic [3:0] c,
                                 input logic [63:0] pc, input logic [63:0] tgt,
                                 input bit zero, input bit sf, input logic [3:0] nz,
                                 input bit fl, input bit ordy);
        @(negedge clk);
        in_valid  = v;
        in_op     = br_op_t'(3'(op));
        in_cond   = c;
        in_pc     = pc;
        in_target = tgt;
        in_zero   = zero;
        set_flags = sf;
        alu_nzcv  = nz;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] rPc;
        logic [63:0] rTgt;
        bit expLt;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_op     = BR_NONE;
        in_cond   = 4'h0;
        in_pc     = '0;
        in_target = '0;
        in_zero   = 1'b0;
        set_flags = 1'b0;
        alu_nzcv  = 4'h0;
        flush     = 1'b0;
        out_ready = 1'b1;

        tick();
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.out_taken", 64'(out_taken), 64'd0);
        checkOutput("reset.out_next_pc", out_next_pc, 64'd0);
        checkOutput("reset.flags_q", 64'(flags_q), 64'd0);
        checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(1, 2, 4'h0, 64'h100, 64'h200, 1, 0, 4'h0, 0, 1);
        tick();
        checkOutput("cbz.out_valid", 64'(out_valid), 64'd1);
        checkOutput("cbz.out_taken", 64'(out_taken), 64'd1);
        checkOutput("cbz.out_next_pc", out_next_pc, 64'h200);

        applyStimulus(1, 3, 4'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1234, 1, 0, 4'h0, 0, 1);
        tick();
        checkOutput("cbnz_wrap.out_taken", 64'(out_taken), 64'd0);
        checkOutput("cbnz_wrap.out_next_pc", out_next_pc, 64'd0);

`ifdef BRANCH_FLAG_FWD_EN
        expLt = 1'b1;
`else
        expLt = 1'b0;
`endif
        applyStimulus(1, 4, COND_LT, 64'h40, 64'h80, 0, 1, 4'b1000, 0, 1);
        tick();
        checkOutput("bcond_lt.out_taken", 64'(out_taken), 64'(expLt));
        checkOutput("bcond_lt.out_next_pc", out_next_pc, expLt ? 64'h80 : 64'h44);
        checkOutput("bcond_lt.flags_q", 64'(flags_q), 64'b1000);

        applyStimulus(1, 1, 4'h0, 64'h300, 64'h400, 0, 0, 4'h0, 0, 1);
        tick();
        checkOutput("b.out_next_pc", out_next_pc, 64'h400);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 2, 4'h0, 64'h500, 64'h900, 0, 0, 4'h0, 0, 0);
            tick();
            checkOutput("stall.in_ready", 64'(in_ready), 64'd0);
            checkOutput("stall.out_valid", 64'(out_valid), 64'd1);
            checkOutput("stall.out_taken", 64'(out_taken), 64'd1);
            checkOutput("stall.out_next_pc", out_next_pc, 64'h400);
        end
        applyStimulus(1, 2, 4'h0, 64'h500, 64'h900, 0, 0, 4'h0, 0, 1);
        #1;
        checkOutput("drain.in_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("drain.out_taken", 64'(out_taken), 64'd0);
        checkOutput("drain.out_next_pc", out_next_pc, 64'h504);

        applyStimulus(1, 1, 4'h0, 64'h600, 64'h700, 0, 0, 4'h0, 1, 0);
        tick();
        checkOutput("flush.out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush.flags_q", 64'(flags_q), 64'b1000);

        applyStimulus(1, 1, 4'h0, 64'h10, 64'h20, 0, 1, 4'hF, 0, 1);
        tick();
        checkOutput("preReset.flags_q", 64'(flags_q), 64'hF);
        checkOutput("preReset.out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncReset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("asyncReset.out_taken", 64'(out_taken), 64'd0);
        checkOutput("asyncReset.out_next_pc", out_next_pc, 64'd0);
        checkOutput("asyncReset.flags_q", 64'(flags_q), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            rPc  = {$urandom, $urandom};
            rTgt = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rPc = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 12));
            applyStimulus($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), 4'($urandom),
                          rPc, rTgt, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                          4'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
